// File: rtl/instr_enc_loader_if.sv
// Bus bundle for instr_enc_loader.
//   in_*   : field-bundle stream into the encoder (valid/ready handshake)
//   imem_* : write port towards instruction memory (we held until ready)
// slave  = encoder/loader view, master = bundle source / imem model view.
interface instr_enc_loader_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid_i;
   logic              in_ready_o;
   logic [2:0]        in_class_i3;
   logic [4:0]        in_rs_i5;
   logic [4:0]        in_rt_i5;
   logic [4:0]        in_rd_i5;
   logic [4:0]        in_shamt_i5;
   logic [5:0]        in_funct_i6;
   logic [15:0]       in_imm_i16;
   logic [25:0]       in_target_i26;
   logic              in_last_i;
   logic              imem_we_o;
   logic              imem_ready_i;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_wdata_o;

   modport slave (
      input  in_valid_i, in_class_i3, in_rs_i5, in_rt_i5, in_rd_i5, in_shamt_i5,
             in_funct_i6, in_imm_i16, in_target_i26, in_last_i, imem_ready_i,
      output in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
   );

   modport master (
      output in_valid_i, in_class_i3, in_rs_i5, in_rt_i5, in_rd_i5, in_shamt_i5,
             in_funct_i6, in_imm_i16, in_target_i26, in_last_i, imem_ready_i,
      input  in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
   );
endinterface

// File: rtl/instr_enc_loader.sv
// instr_enc_loader: packs MIPS instruction fields (R/LW/SW/BEQ/J/ADDI) into
// 32-bit words, buffers them in a small FIFO and streams them into imem at
// sequential word addresses starting at BASE_ADDR.
// Ports:
//   clk_i, reset_n_i : clock (rising edge), async active-low reset
//   start_i          : begin a load session (honoured in IDLE/DONE only)
//   bus (slave)      : field-bundle input stream + imem write port
//   busy_o / done_o  : state LOAD / state DONE
//   err_o            : sticky, illegal class seen this session
//   count_o          : words written this session
module instr_enc_loader #(
   parameter int                FIFO_DEPTH = 4,
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             start_i,
   instr_enc_loader_if.slave bus,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t                  state_q;
   logic [31:0]             mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   last_q;
   logic [PTR_W:0]          wr_q, rd_q;        // extra MSB distinguishes full/empty
   logic [ADDR_W-1:0]       addr_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    err_q;
   logic                    seen_q;            // last bundle already accepted

   logic [PTR_W-1:0]        wr_idx, rd_idx, tail_idx;
   logic [PTR_W:0]          occ;
   logic                    fifo_empty, fifo_full;
   logic                    in_ready, accept, legal, push, pop;
   logic                    ill_last, last_drains, fin, mark_tail;
   logic [31:0]             enc_word;

   assign wr_idx     = wr_q[PTR_W-1:0];
   assign rd_idx     = rd_q[PTR_W-1:0];
   assign tail_idx   = wr_idx - PTR_W'(1);
   assign occ        = wr_q - rd_q;
   assign fifo_empty = (wr_q == rd_q);
   assign fifo_full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_idx == rd_idx);

   assign in_ready = (state_q == S_LOAD) && !fifo_full && !seen_q;
   assign accept   = bus.in_valid_i && in_ready;
   assign push     = accept && legal;
   assign pop      = (state_q == S_LOAD) && !fifo_empty && bus.imem_ready_i;

   // An illegal bundle carrying the last flag hands "last" to the newest
   // queued word. If no such word survives this edge (FIFO empty, or its only
   // entry is being popped right now) the session ends here instead.
   assign ill_last    = accept && !legal && bus.in_last_i;
   assign last_drains = pop && (occ == (PTR_W+1)'(1));
   assign mark_tail   = ill_last && !fifo_empty && !last_drains;
   assign fin         = (pop && last_q[rd_idx]) || (ill_last && (fifo_empty || last_drains));

   always_comb begin
      enc_word = '0;
      legal    = 1'b1;
      case (bus.in_class_i3)
         3'd0: enc_word = {6'b000000, bus.in_rs_i5, bus.in_rt_i5, bus.in_rd_i5,
                           bus.in_shamt_i5, bus.in_funct_i6};
         3'd1: enc_word = {6'b100011, bus.in_rs_i5, bus.in_rt_i5, bus.in_imm_i16};
         3'd2: enc_word = {6'b101011, bus.in_rs_i5, bus.in_rt_i5, bus.in_imm_i16};
         3'd3: enc_word = {6'b000100, bus.in_rs_i5, bus.in_rt_i5, bus.in_imm_i16};
         3'd4: enc_word = {6'b000010, bus.in_target_i26};
         3'd5: enc_word = {6'b001000, bus.in_rs_i5, bus.in_rt_i5, bus.in_imm_i16};
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         last_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         addr_q  <= BASE_ADDR;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (push) begin
                  mem_q[wr_idx]  <= enc_word;
                  last_q[wr_idx] <= bus.in_last_i;
                  wr_q           <= wr_q + (PTR_W+1)'(1);
               end
               if (mark_tail) last_q[tail_idx] <= 1'b1;
               if (pop) begin
                  rd_q   <= rd_q + (PTR_W+1)'(1);
                  addr_q <= addr_q + ADDR_W'(4);
                  cnt_q  <= cnt_q + CNT_W'(1);
               end
               if (accept && bus.in_last_i) seen_q <= 1'b1;
               if (accept && !legal)        err_q  <= 1'b1;
               if (fin)                     state_q <= S_DONE;
            end
            default: begin
               // IDLE and DONE: a new session restarts everything from scratch
               if (start_i) begin
                  state_q <= S_LOAD;
                  last_q  <= '0;
                  wr_q    <= '0;
                  rd_q    <= '0;
                  addr_q  <= BASE_ADDR;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  seen_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.in_ready_o   = in_ready;
   assign bus.imem_we_o    = (state_q == S_LOAD) && !fifo_empty;
   assign bus.imem_addr_o  = addr_q;
   assign bus.imem_wdata_o = mem_q[rd_idx];
   assign busy_o           = (state_q == S_LOAD);
   assign done_o           = (state_q == S_DONE);
   assign err_o            = err_q;
   assign count_o          = cnt_q;
endmodule

// File: tb/tb_instr_enc_loader.sv
module tb_instr_enc_loader;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, err, busy_w, done_w, err_w;
   logic [15:0] cnt, cnt_w;

   instr_enc_loader_if #(.ADDR_W(32)) bus ();
   instr_enc_loader_if #(.ADDR_W(4))  bw ();

   instr_enc_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0), .CNT_W(16)) u_dut (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .bus(bus.slave),
      .busy_o(busy), .done_o(done), .err_o(err), .count_o(cnt));

   // narrow-address copy fed the same stimulus, to observe address wrap
   instr_enc_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(4'hC), .CNT_W(16)) u_wrap (
      .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .bus(bw.slave),
      .busy_o(busy_w), .done_o(done_w), .err_o(err_w), .count_o(cnt_w));

   assign bw.in_valid_i    = bus.in_valid_i;
   assign bw.in_class_i3   = bus.in_class_i3;
   assign bw.in_rs_i5      = bus.in_rs_i5;
   assign bw.in_rt_i5      = bus.in_rt_i5;
   assign bw.in_rd_i5      = bus.in_rd_i5;
   assign bw.in_shamt_i5   = bus.in_shamt_i5;
   assign bw.in_funct_i6   = bus.in_funct_i6;
   assign bw.in_imm_i16    = bus.in_imm_i16;
   assign bw.in_target_i26 = bus.in_target_i26;
   assign bw.in_last_i     = bus.in_last_i;
   assign bw.imem_ready_i  = bus.imem_ready_i;

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cls;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic        last;
   } bnd_t;

   bnd_t        pend[$];
   int          n_chk = 0, n_fail = 0;
   int          ready_pct = 100, valid_pct = 100, start_pct = 0, stall = 0, acc_cnt = 0;
   logic [31:0] wlog_d[$], wlog_a[$];

   // reference model: 0=IDLE 1=LOAD 2=DONE, queue of pending words
   int          m_st;
   logic [31:0] mq[$];
   bit          ml[$];
   bit          m_seen, m_err;
   logic [31:0] m_addr;
   logic [15:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input bnd_t b);
      logic [31:0] op;
      case (b.cls)
         3'd0: op = 32'd0;
         3'd1: op = 32'd35;
         3'd2: op = 32'd43;
         3'd3: op = 32'd4;
         3'd4: op = 32'd2;
         default: op = 32'd8;
      endcase
      if (b.cls == 3'd0)
         return op * 32'h0400_0000 + 32'(b.rs) * 32'h20_0000 + 32'(b.rt) * 32'h1_0000
              + 32'(b.rd) * 32'd2048 + 32'(b.sh) * 32'd64 + 32'(b.fn);
      else if (b.cls == 3'd4)
         return op * 32'h0400_0000 + 32'(b.tgt);
      else
         return op * 32'h0400_0000 + 32'(b.rs) * 32'h20_0000 + 32'(b.rt) * 32'h1_0000 + 32'(b.imm);
   endfunction

   function automatic bnd_t mk(input int cls, rs, rt, rd, sh, fn, imm, tgt, input bit last);
      bnd_t b;
      b.cls = 3'(cls); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd); b.sh = 5'(sh);
      b.fn = 6'(fn); b.imm = 16'(imm); b.tgt = 26'(tgt); b.last = last;
      return b;
   endfunction

   function automatic bnd_t rnd_bnd(input bit legal_only, input bit last);
      return mk(legal_only ? $urandom_range(0, 5) : $urandom_range(0, 7), $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom, last);
   endfunction

   task automatic model_reset();
      m_st = 0; mq.delete(); ml.delete(); m_seen = 0; m_err = 0;
      m_addr = 32'h0; m_cnt = 16'h0;
   endtask

   task automatic model_step();
      bit   rdy, we, acc, pop, fin, pl;
      bnd_t b;
      rdy = (m_st == 1) && (mq.size() < DEPTH) && !m_seen;
      we  = (m_st == 1) && (mq.size() > 0);
      if (m_st != 1) begin
         if (start) begin
            m_st = 1; mq.delete(); ml.delete(); m_seen = 0; m_err = 0;
            m_addr = 32'h0; m_cnt = 16'h0;
         end
      end else begin
         acc = bus.in_valid_i && rdy;
         pop = we && bus.imem_ready_i;
         fin = 0;
         if (pop) begin
            pl = ml.pop_front();
            void'(mq.pop_front());
            m_addr = m_addr + 32'd4;
            m_cnt  = m_cnt + 16'd1;
            if (pl) fin = 1;
         end
         if (acc) begin
            b = pend.pop_front();
            if (b.last) m_seen = 1;
            if (b.cls < 3'd6) begin
               mq.push_back(ref_word(b));
               ml.push_back(b.last);
            end else begin
               m_err = 1;
               if (b.last) begin
                  if (mq.size() == 0) fin = 1;
                  else ml[ml.size()-1] = 1'b1;
               end
            end
         end
         if (fin) m_st = 2;
      end
   endtask

   task automatic cycle(input bit st);
      bit   exp_rdy, exp_we;
      bnd_t b;
      @(negedge clk);
      exp_rdy = (m_st == 1) && (mq.size() < DEPTH) && !m_seen;
      exp_we  = (m_st == 1) && (mq.size() > 0);
      chk("in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
      chk("imem_we", 32'(bus.imem_we_o), 32'(exp_we));
      chk("imem_addr", bus.imem_addr_o, m_addr);
      if (exp_we) chk("imem_wdata", bus.imem_wdata_o, mq[0]);
      chk("busy", 32'(busy), 32'(m_st == 1));
      chk("done", 32'(done), 32'(m_st == 2));
      chk("err", 32'(err), 32'(m_err));
      chk("count", 32'(cnt), 32'(m_cnt));
      chk("w_addr", 32'(bw.imem_addr_o), 32'(4'(32'd12 + 32'd4 * 32'(m_cnt))));
      chk("w_hs", 32'({bw.in_ready_o, bw.imem_we_o}), 32'({exp_rdy, exp_we}));
      chk("w_stat", 32'({busy_w, done_w, err_w}), 32'({m_st == 1, m_st == 2, m_err}));
      chk("w_count", 32'(cnt_w), 32'(m_cnt));
      if (exp_we) chk("w_wdata", bw.imem_wdata_o, mq[0]);
      // drive next inputs
      start = st;
      bus.in_valid_i = (pend.size() > 0) && ($urandom_range(0, 99) < valid_pct);
      b = (pend.size() > 0) ? pend[0] : rnd_bnd(1'b0, 1'b0);
      bus.in_class_i3 = b.cls; bus.in_rs_i5 = b.rs; bus.in_rt_i5 = b.rt;
      bus.in_rd_i5 = b.rd; bus.in_shamt_i5 = b.sh; bus.in_funct_i6 = b.fn;
      bus.in_imm_i16 = b.imm; bus.in_target_i26 = b.tgt; bus.in_last_i = b.last;
      if (stall > 0) begin
         bus.imem_ready_i = 1'b0;
         stall--;
      end else begin
         bus.imem_ready_i = ($urandom_range(0, 99) < ready_pct);
      end
      if (bus.imem_we_o && bus.imem_ready_i) begin
         wlog_d.push_back(bus.imem_wdata_o);
         wlog_a.push_back(bus.imem_addr_o);
      end
      if (bus.in_valid_i && bus.in_ready_o) acc_cnt++;
      @(posedge clk);
      model_step();
   endtask

   task automatic finish_session();
      int k = 0;
      while (m_st != 2 && k < 400) begin
         cycle($urandom_range(0, 99) < start_pct);
         k++;
      end
      #1;
      chk("session_done", 32'(done), 32'd1);
      pend.delete();
   endtask

   task automatic session(input int rp, input int vp, input int sp);
      ready_pct = rp; valid_pct = vp; start_pct = sp;
      wlog_d.delete(); wlog_a.delete(); acc_cnt = 0;
      cycle(1'b1);
      finish_session();
   endtask

   task automatic chk_log(input string tag, input int i, input logic [31:0] d, input logic [31:0] a);
      if (i < wlog_d.size()) begin
         chk({tag, "_data"}, wlog_d[i], d);
         chk({tag, "_addr"}, wlog_a[i], a);
      end else begin
         chk({tag, "_missing"}, 32'(wlog_d.size()), 32'(i + 1));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bnd_t t3[$];
      bus.in_valid_i = 1'b0; bus.imem_ready_i = 1'b0; bus.in_last_i = 1'b0;
      bus.in_class_i3 = '0; bus.in_rs_i5 = '0; bus.in_rt_i5 = '0; bus.in_rd_i5 = '0;
      bus.in_shamt_i5 = '0; bus.in_funct_i6 = '0; bus.in_imm_i16 = '0; bus.in_target_i26 = '0;
      model_reset();
      #12;
      chk("rst_out", 32'({bus.in_ready_o, bus.imem_we_o, busy, done, err}), 32'd0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);
      chk("rst_wdata", bus.imem_wdata_o, 32'h0);
      chk("rst_count", 32'(cnt), 32'd0);
      chk("rst_w_addr", 32'(bw.imem_addr_o), 32'hC);
      rst_n = 1'b1;

      // T1: single R-type
      pend.push_back(mk(0, 1, 2, 3, 0, 'h20, 0, 0, 1));
      session(100, 100, 0);
      chk("t1_n", 32'(wlog_d.size()), 32'd1);
      chk_log("t1_w0", 0, 32'h0022_1820, 32'h0);
      chk("t1_count", 32'(cnt), 32'd1);

      // T2: LW, SW, J
      pend.push_back(mk(1, 0, 8, 0, 0, 0, 'h4, 0, 0));
      pend.push_back(mk(2, 0, 8, 0, 0, 0, 'h8, 0, 0));
      pend.push_back(mk(4, 0, 0, 0, 0, 0, 0, 'h10, 1));
      session(100, 100, 0);
      chk_log("t2_w0", 0, 32'h8C08_0004, 32'h0);
      chk_log("t2_w1", 1, 32'hAC08_0008, 32'h4);
      chk_log("t2_w2", 2, 32'h0800_0010, 32'h8);
      chk("t2_count", 32'(cnt), 32'd3);
      chk("t2_w_addr_end", 32'(bw.imem_addr_o), 32'h8);

      // T3: imem stalls, FIFO fills after 4 accepts
      t3.delete();
      for (int i = 0; i < 5; i++) t3.push_back(rnd_bnd(1'b1, i == 4));
      foreach (t3[i]) pend.push_back(t3[i]);
      ready_pct = 100; valid_pct = 100; start_pct = 0; stall = 6;
      wlog_d.delete(); wlog_a.delete(); acc_cnt = 0;
      cycle(1'b1);
      repeat (5) cycle(1'b0);
      #1;
      chk("t3_accepts", 32'(acc_cnt), 32'd4);
      chk("t3_head", bus.imem_wdata_o, ref_word(t3[0]));
      finish_session();
      for (int i = 0; i < 5; i++) chk_log("t3_w", i, ref_word(t3[i]), 32'(4 * i));

      // T4: illegal class in the middle
      pend.push_back(mk(3, 1, 2, 0, 0, 0, 'hFFFF, 0, 0));
      pend.push_back(mk(7, 3, 3, 3, 3, 3, 3, 3, 0));
      pend.push_back(mk(5, 0, 9, 0, 0, 0, 5, 0, 1));
      session(100, 100, 0);
      chk("t4_n", 32'(wlog_d.size()), 32'd2);
      chk_log("t4_w0", 0, 32'h1022_FFFF, 32'h0);
      chk_log("t4_w1", 1, 32'h2009_0005, 32'h4);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_count", 32'(cnt), 32'd2);

      // T6: reset mid-stall with 3 words queued
      for (int i = 0; i < 3; i++) pend.push_back(rnd_bnd(1'b1, 1'b0));
      ready_pct = 100; valid_pct = 100; start_pct = 0; stall = 100;
      cycle(1'b1);
      repeat (5) cycle(1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_out", 32'({bus.in_ready_o, bus.imem_we_o, busy, done, err}), 32'd0);
      chk("t6_addr", bus.imem_addr_o, 32'h0);
      chk("t6_wdata", bus.imem_wdata_o, 32'h0);
      chk("t6_count", 32'(cnt), 32'd0);
      chk("t6_w_addr", 32'(bw.imem_addr_o), 32'hC);
      model_reset();
      pend.delete();
      stall = 0;
      #2;
      rst_n = 1'b1;
      pend.push_back(mk(5, 1, 1, 0, 0, 0, 7, 0, 0));
      pend.push_back(mk(0, 4, 5, 6, 1, 2, 0, 0, 1));
      session(100, 100, 0);
      chk_log("t6_w0", 0, 32'h2021_0007, 32'h0);
      chk("t6_count_end", 32'(cnt), 32'd2);

      // randomized sessions, including illegal classes and stray start_i
      repeat (20) begin
         int n;
         n = $urandom_range(1, 9);
         for (int i = 0; i < n; i++) pend.push_back(rnd_bnd(1'b0, i == n - 1));
         session($urandom_range(30, 100), $urandom_range(30, 100), 10);
      end

      repeat (2) cycle(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
